pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. It drives the hold and bubble controls of
//  the pc, if_id, id_ex, ex_mem and mem_wb registers. It resolves three hazard classes:
//  - load-use;
//  - taken branch/jump;
//  - multi-cycle data-memory access (req/ready handshake) with a timeout watchdog.
//  It sits beside the pipeline registers and is their only source of stall/flush.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/hz_load_use_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, the bundle of
// stall/flush controls, and the hard-wired zero register number.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } hz_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hz_load_use_detect.sv
// Load-use compare: the load in EX produces a register the ID instruction
// reads, so ID must wait one cycle for the value to become forwardable.
module hz_load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_to_reg,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs && (id_rs == ex_rd);
  assign rt_match = id_uses_rt && (id_rt == ex_rd);

  // Writes to r0 are discarded, so they never create a dependency.
  assign load_use = ex_mem_to_reg && ex_reg_write && (ex_rd != REG_ZERO) &&
                    (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze with watchdog,
// control-hazard squash and load-use bubble, plus a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hz_state_t       state;
  logic [WC_W-1:0] wait_cnt;
  logic            load_use;
  logic            ctrl_hazard;
  logic            memfreeze;
  hz_ctrl_t        ctrl;

  hz_load_use_detect u_load_use (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .load_use      (load_use)
  );

  assign ctrl_hazard = ex_branch_taken || ex_jump;
  assign memfreeze   = ((state == RUN) && mem_req && !mem_ready) ||
                       ((state == MEM_WAIT) && !mem_ready) ||
                       (state == ERROR);

  // Priority: reset, memory freeze, control hazard, load-use.
  always_comb begin
    ctrl = '0;
    if (reset) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
    end else if (memfreeze) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
    end else if (ctrl_hazard) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
    end else if (load_use) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_stall  = ctrl.id_ex_stall;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (ctrl.pc_stall && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WC_LAST) begin
            state       <= ERROR;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERROR: begin
          mem_timeout <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;
  localparam int CNT_SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             id_uses_rs, id_uses_rt;
  logic             ex_reg_write, ex_mem_to_reg, ex_branch_taken, ex_jump;
  logic             mem_req, mem_ready;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic             ex_mem_stall, mem_wb_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  // Model: memory-wait bookkeeping, sticky error and saturating stall count.
  bit m_waiting;
  int m_waits;
  bit m_error;
  int m_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
  function automatic logic [6:0] obs_vec();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};
  endfunction

  function automatic bit model_freeze();
    if (m_error) return 1'b1;
    if (m_waiting) return !mem_ready;
    return mem_req && !mem_ready;
  endfunction

  function automatic logic [6:0] exp_vec();
    bit lu;
    lu = ex_mem_to_reg && ex_reg_write && (ex_rd != 0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (reset) return 7'b0010101;
    if (model_freeze()) return 7'b1101011;
    if (ex_branch_taken || ex_jump) return 7'b0010100;
    if (lu) return 7'b1100100;
    return 7'b0000000;
  endfunction

  // Advance one clock: update the model with the inputs seen at the edge.
  task automatic advance();
    logic [6:0] e;
    @(posedge clk);
    e = exp_vec();
    if (reset) begin
      m_waiting = 0; m_waits = 0; m_error = 0; m_cnt = 0;
    end else begin
      if (e[6] && m_cnt < CNT_SAT) m_cnt++;
      if (m_error) begin
      end else if (m_waiting) begin
        if (mem_ready) begin
          m_waiting = 0; m_waits = 0;
        end else begin
          m_waits++;
          if (m_waits == MEM_TIMEOUT) m_error = 1;
        end
      end else if (mem_req && !mem_ready) begin
        m_waiting = 1; m_waits = 0;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_to_reg = 0; ex_branch_taken = 0;
    ex_jump = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd = rd; id_rs = 5'd5; id_uses_rs = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; mem_req = 1; set_load_use(5'd5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== 7'b0010101) begin
        failures++; $display("FAIL reset_ctrl cyc%0d got=%b want=%b", i, obs_vec(), 7'b0010101);
      end
      advance();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (obs_vec() !== 7'b0 || stall_cycles !== 0 || mem_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_release got=%b cnt=%0d to=%b want=0000000 cnt=0 to=0",
                           obs_vec(), stall_cycles, mem_timeout);
    end
    advance();
  endtask

  task automatic test_load_use();
    logic [4:0] rds [2] = '{5'd5, 5'd0};
    foreach (rds[k]) begin
      clear_inputs(); set_load_use(rds[k]);
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL load_use rd=%0d got=%b want=%b", rds[k], obs_vec(), exp_vec());
      end
      advance();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (obs_vec() !== 7'b0 || stall_cycles !== CNT_W'(m_cnt)) begin
        failures++; $display("FAIL load_use_after rd=%0d got=%b cnt=%0d want=0000000 cnt=%0d",
                             rds[k], obs_vec(), stall_cycles, m_cnt);
      end
      advance();
    end
  endtask

  task automatic test_branch_priority();
    clear_inputs(); set_load_use(5'd5); ex_branch_taken = 1;
    @(negedge clk);
    checks++;
    if (obs_vec() !== 7'b0010100) begin
      failures++; $display("FAIL branch_over_lu got=%b want=%b", obs_vec(), 7'b0010100);
    end
    advance();
    clear_inputs(); ex_jump = 1;
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL jump got=%b want=%b", obs_vec(), exp_vec());
    end
    advance();
  endtask

  task automatic test_mem_wait();
    int cnt0;
    clear_inputs(); set_load_use(5'd5); ex_branch_taken = 1;
    cnt0 = m_cnt;
    for (int i = 0; i < 5; i++) begin
      mem_req = 1; mem_ready = (i == 3);
      if (i == 4) begin mem_req = 1; mem_ready = 1; ex_branch_taken = 0; set_load_use(5'd0); end
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec() || stall_cycles !== CNT_W'(m_cnt)) begin
        failures++; $display("FAIL mem_wait cyc%0d got=%b cnt=%0d want=%b cnt=%0d",
                             i, obs_vec(), stall_cycles, exp_vec(), m_cnt);
      end
      advance();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (stall_cycles !== CNT_W'((cnt0 + 3 > CNT_SAT) ? CNT_SAT : cnt0 + 3)) begin
      failures++; $display("FAIL mem_wait_count got=%0d want=%0d", stall_cycles, m_cnt);
    end
    advance();
  endtask

  task automatic test_timeout();
    clear_inputs(); mem_req = 1;
    for (int i = 0; i < MEM_TIMEOUT + 4; i++) begin
      if (i >= MEM_TIMEOUT + 2) mem_ready = 1;
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec() || mem_timeout !== m_error || stall_cycles !== CNT_W'(m_cnt)) begin
        failures++; $display("FAIL timeout cyc%0d got=%b to=%b cnt=%0d want=%b to=%b cnt=%0d",
                             i, obs_vec(), mem_timeout, stall_cycles, exp_vec(), m_error, m_cnt);
      end
      advance();
    end
    checks++;
    if (mem_timeout !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky got=%b want=1", mem_timeout);
    end
    reset = 1;
    advance();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (mem_timeout !== 1'b0 || obs_vec() !== 7'b0 || stall_cycles !== 0) begin
      failures++; $display("FAIL timeout_reset to=%b got=%b cnt=%0d want to=0 0000000 cnt=0",
                           mem_timeout, obs_vec(), stall_cycles);
    end
    advance();
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs(); mem_req = 1;
    advance(); advance();
    reset = 1;
    @(negedge clk);
    checks++;
    if (obs_vec() !== 7'b0010101) begin
      failures++; $display("FAIL reset_mid_wait got=%b want=0010101", obs_vec());
    end
    advance();
    reset = 0; mem_req = 0;
    @(negedge clk);
    checks++;
    if (obs_vec() !== 7'b0 || stall_cycles !== 0) begin
      failures++; $display("FAIL after_mid_reset got=%b cnt=%0d want=0000000 cnt=0", obs_vec(), stall_cycles);
    end
    advance();
    // Fresh wait must get the full timeout budget again.
    mem_req = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) advance();
    @(negedge clk);
    checks++;
    if (mem_timeout !== m_error) begin
      failures++; $display("FAIL wait_cnt_cleared to=%b want=%b", mem_timeout, m_error);
    end
    reset = 1; advance(); clear_inputs();
  endtask

  task automatic test_saturation();
    clear_inputs(); mem_req = 1;
    for (int i = 0; i < CNT_SAT + 4; i++) begin
      mem_ready = (i % 3 == 2);
      advance();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (stall_cycles !== CNT_W'(CNT_SAT) || m_cnt != CNT_SAT) begin
      failures++; $display("FAIL saturation got=%0d model=%0d want=%0d", stall_cycles, m_cnt, CNT_SAT);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset           = ($urandom_range(0, 24) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs      = $urandom_range(0, 1);
      id_uses_rt      = $urandom_range(0, 1);
      ex_reg_write    = ($urandom_range(0, 3) != 0);
      ex_mem_to_reg   = $urandom_range(0, 1);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_jump         = ($urandom_range(0, 9) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = $urandom_range(0, 1);
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec() || mem_timeout !== m_error || stall_cycles !== CNT_W'(m_cnt)) begin
        failures++; $display("FAIL random it%0d got=%b to=%b cnt=%0d want=%b to=%b cnt=%0d",
                             i, obs_vec(), mem_timeout, stall_cycles, exp_vec(), m_error, m_cnt);
      end
      advance();
    end
  endtask

  initial begin
    clear_inputs();
    m_waiting = 0; m_waits = 0; m_error = 0; m_cnt = 0;
    #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    reset = 1; advance(); clear_inputs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
